// File: rtl/uart_tx_arbiter.sv
// Two-requester 8N1 UART transmitter with per-frame round-robin arbitration.
// A frame in progress is never pre-empted; arbitration happens only in IDLE.
module uart_tx_arbiter #(
    parameter int CLOCK_RATE   = 100_000_000,
    parameter int BAUD_RATE    = 115_200,
    parameter int CLKS_PER_BIT = CLOCK_RATE / BAUD_RATE
) (
    input  logic       clk_pin,
    input  logic       rst_pin,
    input  logic [7:0] req0_data,
    input  logic       req0_valid,
    output logic       req0_ready,
    input  logic [7:0] req1_data,
    input  logic       req1_valid,
    output logic       req1_ready,
    output logic       txd_o,
    output logic       busy,
    output logic       grant
);

    localparam int CNT_W = $clog2(CLKS_PER_BIT);
    localparam logic [CNT_W-1:0] BAUD_LAST = CNT_W'(CLKS_PER_BIT - 1);

    typedef enum logic [1:0] {
        IDLE,
        START,
        DATA,
        STOP
    } state_t;

    state_t           state;
    logic [CNT_W-1:0] baud_cnt;
    logic [2:0]       bit_cnt;
    logic [7:0]       shift_reg;
    logic             last_grant;
    logic             winner;
    logic             take;
    logic             bit_done;
    logic [7:0]       win_data;

    always_comb begin
        // NOTE: default assignment first so every path drives winner and no latch is inferred.
        winner = 1'b0;
        if (req0_valid && req1_valid) begin
            winner = ~last_grant;
        end else if (req1_valid) begin
            winner = 1'b1;
        end
    end

    assign take       = (state == IDLE) && (winner ? req1_valid : req0_valid);
    assign req0_ready = take && !winner;
    assign req1_ready = take && winner;
    assign win_data   = winner ? req1_data : req0_data;
    assign bit_done   = (baud_cnt == BAUD_LAST);

    always_ff @(posedge clk_pin or posedge rst_pin) begin
        if (rst_pin) begin
            state      <= IDLE;
            baud_cnt   <= '0;
            bit_cnt    <= '0;
            // NOTE: the shift register is reset too, so an aborted byte cannot leak into a later frame.
            shift_reg  <= '0;
            last_grant <= 1'b1;
            grant      <= 1'b0;
            txd_o      <= 1'b1;
            busy       <= 1'b0;
        end else begin
            // NOTE: non-blocking assignments keep every register reading pre-edge values.
            unique case (state)
                IDLE: begin
                    baud_cnt <= '0;
                    if (take) begin
                        shift_reg  <= win_data;
                        grant      <= winner;
                        last_grant <= winner;
                        txd_o      <= 1'b0;
                        busy       <= 1'b1;
                        state      <= START;
                    end
                end
                START: begin
                    if (bit_done) begin
                        baud_cnt  <= '0;
                        bit_cnt   <= '0;
                        txd_o     <= shift_reg[0];
                        shift_reg <= shift_reg >> 1;
                        state     <= DATA;
                    end else begin
                        baud_cnt <= baud_cnt + 1'b1;
                    end
                end
                DATA: begin
                    if (bit_done) begin
                        baud_cnt <= '0;
                        bit_cnt  <= bit_cnt + 1'b1;
                        if (bit_cnt == 3'd7) begin
                            txd_o <= 1'b1;
                            state <= STOP;
                        end else begin
                            txd_o     <= shift_reg[0];
                            shift_reg <= shift_reg >> 1;
                        end
                    end else begin
                        baud_cnt <= baud_cnt + 1'b1;
                    end
                end
                STOP: begin
                    if (bit_done) begin
                        baud_cnt <= '0;
                        busy     <= 1'b0;
                        state    <= IDLE;
                    end else begin
                        baud_cnt <= baud_cnt + 1'b1;
                    end
                end
            endcase
        end
    end

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// Self-checking bench: per-cycle reference model of line, busy, grant and ready,
// directed scenarios plus a randomized traffic phase, and a short-bit-period instance.
module tb_uart_tx_arbiter;

    localparam int C  = 10;
    localparam int C2 = 2;

    logic clk = 1'b0;
    logic rst = 1'b1;

    logic [7:0] d0 = 8'h00, d1 = 8'h00;
    logic       v0 = 1'b0, v1 = 1'b0;
    logic       r0, r1, txd, busy, grant;

    logic [7:0] s_d0 = 8'h00, s_d1 = 8'h00;
    logic       s_v0 = 1'b0, s_v1 = 1'b0;
    logic       s_r0, s_r1, s_txd, s_busy, s_grant;

    int checks   = 0;
    int failures = 0;
    int cyc      = 0;

    logic [7:0] q0[$], q1[$];
    logic [7:0] exp0[$], exp1[$];
    int         log_cyc[$];
    logic [7:0] log_byte[$];
    logic       log_grant[$];

    logic       m_last  = 1'b1;
    logic       m_grant = 1'b0;
    logic       m_have  = 1'b0;
    int         m_hs    = 0;
    logic [7:0] m_byte  = 8'h00;
    int         m_n;
    logic       m_busy, m_txd, m_win, m_rdy0, m_rdy1;

    uart_tx_arbiter #(.CLOCK_RATE(1000), .BAUD_RATE(100)) dut (
        .clk_pin(clk), .rst_pin(rst),
        .req0_data(d0), .req0_valid(v0), .req0_ready(r0),
        .req1_data(d1), .req1_valid(v1), .req1_ready(r1),
        .txd_o(txd), .busy(busy), .grant(grant)
    );

    uart_tx_arbiter #(.CLOCK_RATE(1000), .BAUD_RATE(100), .CLKS_PER_BIT(C2)) dut_short (
        .clk_pin(clk), .rst_pin(rst),
        .req0_data(s_d0), .req0_valid(s_v0), .req0_ready(s_r0),
        .req1_data(s_d1), .req1_valid(s_v1), .req1_ready(s_r1),
        .txd_o(s_txd), .busy(s_busy), .grant(s_grant)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, obs, exp, $time);
        end
    endtask

    function automatic logic frame_bit(input logic [7:0] b, input int idx);
        logic [9:0] f;
        f = {1'b1, b, 1'b0};
        return f[idx];
    endfunction

    initial forever begin
        @(posedge clk);
        cyc++;
    end

    // Requesters: a non-empty queue means valid, head of queue is the data.
    initial forever begin
        @(posedge clk);
        #1;
        v0 = (q0.size() > 0);
        d0 = v0 ? q0[0] : 8'h00;
        v1 = (q1.size() > 0);
        d1 = v1 ? q1[0] : 8'h00;
    end

    // Reference model, evaluated mid-cycle.
    initial forever begin
        @(negedge clk);
        if (rst) begin
            check("rst_txd", txd, 1'b1);
            check("rst_busy", busy, 1'b0);
            check("rst_grant", grant, 1'b0);
            check("rst_ready0", r0, 1'b0);
            check("rst_ready1", r1, 1'b0);
            m_last  = 1'b1;
            m_grant = 1'b0;
            m_have  = 1'b0;
        end else begin
            m_n    = cyc - m_hs;
            m_busy = m_have && (m_n >= 1) && (m_n <= 10 * C);
            m_txd  = m_busy ? frame_bit(m_byte, (m_n - 1) / C) : 1'b1;
            m_win  = (v0 && v1) ? !m_last : v1;
            m_rdy0 = !m_busy && v0 && !m_win;
            m_rdy1 = !m_busy && v1 && m_win;
            check("txd", txd, m_txd);
            check("busy", busy, m_busy);
            check("grant", grant, m_grant);
            check("ready0", r0, m_rdy0);
            check("ready1", r1, m_rdy1);
            if (m_rdy0 || m_rdy1) begin
                m_hs    = cyc;
                m_have  = 1'b1;
                m_byte  = m_win ? d1 : d0;
                m_grant = m_win;
                m_last  = m_win;
                log_cyc.push_back(cyc);
                log_byte.push_back(m_byte);
                log_grant.push_back(m_win);
                if (m_win) void'(q1.pop_front());
                else       void'(q0.pop_front());
            end
        end
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic wait_cyc(input int target);
        while (cyc < target) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic wait_log(input string tag, input int n, input int budget);
        int k = 0;
        while (log_byte.size() < n && k < budget) begin
            @(posedge clk);
            #1;
            k++;
        end
        check(tag, (log_byte.size() >= n), 1'b1);
    endtask

    task automatic wait_idle();
        if (log_cyc.size() > 0) wait_cyc(log_cyc[log_cyc.size() - 1] + 10 * C + 2);
    endtask

    task automatic do_reset();
        @(posedge clk);
        #1 rst = 1'b1;
        repeat (3) @(posedge clk);
        #1 rst = 1'b0;
    endtask

    initial begin
        int b, hs, k;
        logic [7:0] rb;
        int got0, got1;

        repeat (3) @(posedge clk);
        #1 rst = 1'b0;

        // 1: single byte from req0
        b = log_byte.size();
        q0.push_back(8'hA5);
        wait_log("t1_hs", b + 1, 50);
        check("t1_byte", log_byte[b], 8'hA5);
        check("t1_grant", log_grant[b], 1'b0);
        wait_idle();

        // 2: continuous contention, grants alternate
        do_reset();
        b = log_byte.size();
        q0.push_back(8'h11); q0.push_back(8'h33);
        q1.push_back(8'h22); q1.push_back(8'h44);
        wait_log("t2_hs", b + 4, 600);
        check("t2_byte0", log_byte[b],     8'h11);
        check("t2_byte1", log_byte[b + 1], 8'h22);
        check("t2_byte2", log_byte[b + 2], 8'h33);
        check("t2_byte3", log_byte[b + 3], 8'h44);
        for (int i = 0; i < 4; i++) check("t2_grant", log_grant[b + i], i[0]);
        for (int i = 0; i < 3; i++) check("t2_gap", log_cyc[b + i + 1] - log_cyc[b + i], 101);
        wait_idle();

        // 3: req1 alone, back-to-back
        do_reset();
        b = log_byte.size();
        q1.push_back(8'h00); q1.push_back(8'hFF);
        wait_log("t3_hs", b + 2, 400);
        check("t3_byte0", log_byte[b], 8'h00);
        check("t3_byte1", log_byte[b + 1], 8'hFF);
        check("t3_grant", log_grant[b + 1], 1'b1);
        check("t3_gap", log_cyc[b + 1] - log_cyc[b], 101);
        wait_idle();

        // 4: req0 arrives mid-frame of req1
        b = log_byte.size();
        q1.push_back(8'h3C);
        wait_log("t4_hs1", b + 1, 50);
        hs = log_cyc[b];
        wait_cyc(hs + 35);
        q0.push_back(8'hA7);
        wait_log("t4_hs0", b + 2, 200);
        check("t4_gap", log_cyc[b + 1] - hs, 101);
        check("t4_byte", log_byte[b + 1], 8'hA7);
        check("t4_grant", log_grant[b + 1], 1'b0);
        wait_idle();

        // 5: reset during data bit 4 of 0x0F
        b = log_byte.size();
        q0.push_back(8'h0F);
        wait_log("t5_hs", b + 1, 50);
        wait_cyc(log_cyc[b] + 5 * C + 3);
        #2 rst = 1'b1;
        #1;
        check("t5_async_txd", txd, 1'b1);
        check("t5_async_busy", busy, 1'b0);
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;
        b = log_byte.size();
        q0.push_back(8'h5A);
        q1.push_back(8'hC3);
        wait_log("t5_hs2", b + 2, 300);
        check("t5_first_grant", log_grant[b], 1'b0);
        check("t5_first_byte", log_byte[b], 8'h5A);
        check("t5_second_byte", log_byte[b + 1], 8'hC3);
        wait_idle();

        // Randomized traffic
        b = log_byte.size();
        for (int i = 0; i < 3000; i++) begin
            @(posedge clk);
            #1;
            if ($urandom_range(0, 29) == 0 && q0.size() < 2) begin
                rb = 8'($urandom);
                q0.push_back(rb);
                exp0.push_back(rb);
            end
            if ($urandom_range(0, 29) == 0 && q1.size() < 2) begin
                rb = 8'($urandom);
                q1.push_back(rb);
                exp1.push_back(rb);
            end
        end
        k = 0;
        while ((q0.size() > 0 || q1.size() > 0) && k < 2000) begin
            @(posedge clk);
            #1;
            k++;
        end
        check("rand_drain", (q0.size() == 0 && q1.size() == 0), 1'b1);
        wait_idle();
        check("rand_count", log_byte.size() - b, exp0.size() + exp1.size());
        got0 = 0;
        got1 = 0;
        for (int i = b; i < log_byte.size(); i++) begin
            if (log_grant[i]) begin
                if (got1 < exp1.size()) check("rand_byte1", log_byte[i], exp1[got1]);
                got1++;
            end else begin
                if (got0 < exp0.size()) check("rand_byte0", log_byte[i], exp0[got0]);
                got0++;
            end
        end
        check("rand_n0", got0, exp0.size());
        check("rand_n1", got1, exp1.size());

        // 6: two-clock bit period, byte 0x80
        @(posedge clk);
        #1;
        s_d0 = 8'h80;
        s_v0 = 1'b1;
        k = 0;
        do begin
            @(negedge clk);
            k++;
        end while (!s_r0 && k < 10);
        check("t6_ready", s_r0, 1'b1);
        @(posedge clk);
        #1 s_v0 = 1'b0;
        for (int i = 0; i < 10 * C2; i++) begin
            @(negedge clk);
            check("t6_txd", s_txd, frame_bit(8'h80, i / C2));
            check("t6_busy", s_busy, 1'b1);
        end
        @(negedge clk);
        check("t6_end_busy", s_busy, 1'b0);
        check("t6_end_txd", s_txd, 1'b1);
        check("t6_grant", s_grant, 1'b0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/uart_tx_arbiter.md
# uart_tx_arbiter

Shares a single 8N1 UART transmit line between two byte-stream requesters, such as the PS GPIO software channel and a PL test source. It serialises each granted byte onto `txd_o` at a fixed baud rate. `txd_o` drives the `rxd_pin` input of the `uart_led` receiver in the lab top level, replacing the bit-banged GPIO path. Arbitration is round-robin per frame, and a frame in progress is never pre-empted.

## Interface

Parameters:
- `CLOCK_RATE`, default 100_000_000: clock frequency in Hz.
- `BAUD_RATE`, default 115_200: line rate in bits per second.
- `CLKS_PER_BIT`, default `CLOCK_RATE/BAUD_RATE` (truncating, so 868 with the defaults): bit period in clocks. It must be at least 2.

Ports:
- `clk_pin`, in, 1: the single clock. All logic is on its rising edge.
- `rst_pin`, in, 1: asynchronous, active-high reset.
- `req0_data`, in, 8: byte offered by requester 0.
- `req0_valid`, in, 1: requester 0 has a byte.
- `req0_ready`, out, 1: byte accepted in this cycle.
- `req1_data`, in, 8: byte offered by requester 1.
- `req1_valid`, in, 1: requester 1 has a byte.
- `req1_ready`, out, 1: byte accepted in this cycle.
- `txd_o`, out, 1: serial line. It idles high.
- `busy`, out, 1: a frame is being transmitted.
- `grant`, out, 1: index of the requester that owns the current or most recent frame.

## Operation

- FSM states: IDLE, START, DATA, STOP.
- Arbitration happens in IDLE only:
  - If exactly one `valid` is high, that requester wins.
  - If both are high, the requester not granted last time wins.
  - `last_grant` resets to 1, so req0 wins the first tie.
- `reqN_ready` is combinational: it is 1 only in IDLE, for the winner, while its `valid` is high. It is 0 in every other state. `ready` depends on `valid`; `valid` must never depend on `ready`.
- Handshake occurs when `valid & ready` at a rising edge. On that edge:
  - `data` is captured into the shift register.
  - `grant` and `last_grant` are updated.
  - The state moves to START.
  - Requesters must hold `data` and `valid` stable until the handshake.
- Frame format: start bit 0, then 8 data bits LSB first, then stop bit 1.
- Each bit lasts exactly `CLKS_PER_BIT` clocks, timed by a baud counter that reloads at every bit boundary.
- State transitions:
  - START goes to DATA after one bit period.
  - DATA goes to STOP after 8 bit periods, tracked by a 3-bit counter that wraps 7 to 0.
  - STOP goes to IDLE after one bit period.
- `txd_o` is registered and glitch-free, and is 1 in IDLE.
- `busy` is 1 in START, DATA and STOP.
- `valid` asserted mid-frame is ignored until IDLE. It is not queued inside the block.
- Reset mid-frame aborts the frame:
  - `txd_o` goes to 1 asynchronously.
  - The captured byte is discarded.
  - Requesters see no `ready` for the lost byte.

## Timing

Reset values:
- `txd_o`=1, `busy`=0, `grant`=0, `req0_ready`=0, `req1_ready`=0.
- State IDLE, all counters 0, `last_grant`=1.

Handshake at edge T (C = `CLKS_PER_BIT`):
- Start bit: `txd_o`=0 during cycles T+1 … T+C.
- Data bit k: cycles T+(k+1)C+1 … T+(k+2)C, for k = 0…7.
- Stop bit: cycles T+9C+1 … T+10C.
- `busy`=1 exactly over cycles T+1 … T+10C.
- State is IDLE at cycle T+10C+1. The earliest next handshake is the edge ending that cycle.
- Minimum frame period is therefore 10C+1 clocks, giving a stop bit of at least C+1 high cycles.
- Latency from `valid` rising in IDLE, with no contention, to `ready` is 0 cycles (same cycle).
- Under continuous contention, grants strictly alternate 0, 1, 0, 1 …
- `grant` holds its value through IDLE until the next handshake.

## Test plan

Use `CLKS_PER_BIT`=10 (`CLOCK_RATE`=1000, `BAUD_RATE`=100) unless noted.

1. `req0` sends 0xA5 after reset → `req0_ready` high for 1 cycle. `txd_o` bit sequence is 0,1,0,1,0,0,1,0,1,1, each bit 10 cycles. `busy` is high for 100 cycles. `grant`=0.
2. From reset, `req0`=0x11 and `req1`=0x22 both held valid, with new bytes 0x33/0x44 presented after each accept → frames are sent in order 0x11, 0x22, 0x33, 0x44. `grant` toggles 0, 1, 0, 1. Handshakes are 101 cycles apart.
3. `req1` only, continuously valid with 0x00 then 0xFF → both frames are sent back-to-back 101 cycles apart with correct bits. `req0_ready` stays 0 throughout.
4. `req0_valid` asserted at cycle 35 of a `req1` frame → `req0_ready` stays 0 until IDLE, then the `req0` handshake occurs at cycle 101 relative to the `req1` handshake.
5. `rst_pin` pulsed during data bit 4 of 0x0F → `txd_o`=1 and `busy`=0 immediately. After release with both requesters valid, `req0` is granted first and its frame is correct.
6. `CLKS_PER_BIT`=2, byte 0x80 → each bit lasts exactly 2 cycles. Bit 7 is the only data 1. The frame spans 20 cycles.
